// File: rtl/ibex_instr_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ibex_instr_bus_responder
//  Purpose  : Instruction-fetch bus responder backed by a preloadable word
//             memory. Grants up to MaxOutstanding requests, answers them in
//             order exactly RspLatency cycles after each grant, and flags
//             misaligned or out-of-range fetches as bus errors.
//  Revision : 1.0 - initial release
// ============================================================================
module ibex_instr_bus_responder #(
    parameter int          MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int          RspLatency     = 2,
    parameter int          MaxOutstanding = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        instr_req_i,
    input  logic [31:0]                 instr_addr_i,
    output logic                        instr_gnt_o,
    output logic                        instr_rvalid_o,
    output logic [31:0]                 instr_rdata_o,
    output logic                        instr_err_o,
    input  logic                        stall_gnt_i,
    input  logic                        load_we_i,
    input  logic [$clog2(MemWords)-1:0] load_idx_i,
    input  logic [31:0]                 load_wdata_i
);

    localparam int          c_idx_w     = $clog2(MemWords);
    localparam int          c_ptr_w     = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [32:0] c_mem_bytes = 33'(MemWords) * 33'd4;
    localparam logic [2:0]  c_max_out   = 3'(MaxOutstanding);
    localparam logic [2:0]  c_cnt_init  = 3'(RspLatency - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(MaxOutstanding - 1);

    // Backing store; deliberately has no reset so preloads survive rst_i
    logic [31:0]        r_mem [MemWords];

    // In-order response FIFO
    logic               r_valid [MaxOutstanding];
    logic               r_err   [MaxOutstanding];
    logic [31:0]        r_data  [MaxOutstanding];
    logic [2:0]         r_cnt   [MaxOutstanding];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [2:0]         r_outstanding;

    logic [31:0]        w_off;
    logic [c_idx_w-1:0] w_idx;
    logic               w_addr_err;
    logic [31:0]        w_rd_word;
    logic               w_gnt;
    logic               w_rvalid;

    // Address decode and grant-time memory read (sees pre-write contents)
    always_comb begin
        w_off      = instr_addr_i - BaseAddr;
        w_idx      = w_off[c_idx_w+1:2];
        w_addr_err = (instr_addr_i[1:0] != 2'b00) || ({1'b0, w_off} >= c_mem_bytes);
        w_rd_word  = w_addr_err ? 32'h0 : r_mem[w_idx];
        // Grant looks only at the registered count, never a same-cycle pop
        w_gnt      = instr_req_i & ~stall_gnt_i & ~rst_i & (r_outstanding < c_max_out);
        w_rvalid   = ~rst_i & (r_outstanding != 3'd0) & r_valid[r_rd_ptr]
                     & (r_cnt[r_rd_ptr] == 3'd0);
    end

    // Response outputs are zero whenever no response is presented
    always_comb begin
        instr_gnt_o    = w_gnt;
        instr_rvalid_o = w_rvalid;
        instr_rdata_o  = w_rvalid ? r_data[r_rd_ptr] : 32'h0;
        instr_err_o    = w_rvalid ? r_err[r_rd_ptr]  : 1'b0;
    end

    // Preload port, independent of bus traffic
    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            r_mem[load_idx_i] <= load_wdata_i;
        end
    end

    // FIFO capture, countdown, pop and outstanding bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= 3'd0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                r_valid[i] <= 1'b0;
                r_err[i]   <= 1'b0;
                r_data[i]  <= 32'h0;
                r_cnt[i]   <= 3'd0;
            end
        end else begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                if (r_valid[i] && (r_cnt[i] != 3'd0)) begin
                    r_cnt[i] <= r_cnt[i] - 3'd1;
                end
            end
            if (w_rvalid) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
            end
            // A push never targets the head slot being popped: a grant needs a free slot
            if (w_gnt) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_err[r_wr_ptr]   <= w_addr_err;
                r_data[r_wr_ptr]  <= w_rd_word;
                r_cnt[r_wr_ptr]   <= c_cnt_init;
                r_wr_ptr          <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
            end
            case ({w_gnt, w_rvalid})
                2'b10:   r_outstanding <= r_outstanding + 3'd1;
                2'b01:   r_outstanding <= r_outstanding - 3'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ibex_instr_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ibex_instr_bus_responder
//  Purpose  : Directed self-checking bench for ibex_instr_bus_responder
//             (default parameters: 1024 words, base 0, latency 2, 2 outstanding).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_instr_bus_responder;

    logic        clk;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;
    logic        stall_gnt;
    logic        load_we;
    logic [9:0]  load_idx;
    logic [31:0] load_wdata;

    int total = 0;
    int bad   = 0;

    ibex_instr_bus_responder dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .instr_err_o    (instr_err),
        .stall_gnt_i    (stall_gnt),
        .load_we_i      (load_we),
        .load_idx_i     (load_idx),
        .load_wdata_i   (load_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are then driven
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks gnt/rvalid/rdata/err together after inputs have settled
    task automatic chk_bus(input string tag, input logic gnt, input logic rv,
                           input logic [31:0] rd, input logic er);
        #2;
        chk32({tag, ".gnt"},    {31'h0, instr_gnt},    {31'h0, gnt});
        chk32({tag, ".rvalid"}, {31'h0, instr_rvalid}, {31'h0, rv});
        chk32({tag, ".rdata"},  instr_rdata,           rd);
        chk32({tag, ".err"},    {31'h0, instr_err},    {31'h0, er});
    endtask

    initial begin
        rst = 1'b1; instr_req = 1'b1; instr_addr = 32'h0; stall_gnt = 1'b0;
        load_we = 1'b1; load_idx = 10'd4; load_wdata = 32'hDEAD_BEEF;
        #1;
        // Reset: gnt suppressed even with req high
        chk_bus("reset", 1'b0, 1'b0, 32'h0, 1'b0);
        tick(); load_idx = 10'd0; load_wdata = 32'h0000_00A0;
        tick(); load_idx = 10'd1; load_wdata = 32'h0000_00A1;
        tick(); load_idx = 10'd2; load_wdata = 32'h0000_00A2;
        tick(); load_we = 1'b0; instr_req = 1'b0;
        chk_bus("reset_hold", 1'b0, 1'b0, 32'h0, 1'b0);
        tick(); rst = 1'b0;
        chk_bus("idle", 1'b0, 1'b0, 32'h0, 1'b0);

        // Basic read: grant T, response T+2
        tick(); instr_req = 1'b1; instr_addr = 32'h10;
        chk_bus("rd_T", 1'b1, 1'b0, 32'h0, 1'b0);
        tick(); instr_req = 1'b0;
        chk_bus("rd_T1", 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_bus("rd_T2", 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        tick();
        chk_bus("rd_T3", 1'b0, 1'b0, 32'h0, 1'b0);

        // Back-to-back with outstanding limit of 2
        tick(); instr_req = 1'b1; instr_addr = 32'h0;
        chk_bus("b2b_0", 1'b1, 1'b0, 32'h0, 1'b0);
        tick(); instr_addr = 32'h4;
        chk_bus("b2b_1", 1'b1, 1'b0, 32'h0, 1'b0);
        tick(); instr_addr = 32'h8;
        chk_bus("b2b_full", 1'b0, 1'b1, 32'h0000_00A0, 1'b0);
        tick();
        chk_bus("b2b_2", 1'b1, 1'b1, 32'h0000_00A1, 1'b0);
        tick(); instr_req = 1'b0;
        chk_bus("b2b_gap", 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_bus("b2b_rsp2", 1'b0, 1'b1, 32'h0000_00A2, 1'b0);

        // Error cases: misaligned and out of range
        tick(); instr_req = 1'b1; instr_addr = 32'h2;
        chk_bus("err_mis", 1'b1, 1'b0, 32'h0, 1'b0);
        tick(); instr_addr = 32'h1000;
        chk_bus("err_oor", 1'b1, 1'b0, 32'h0, 1'b0);
        tick(); instr_req = 1'b0;
        chk_bus("err_rsp_mis", 1'b0, 1'b1, 32'h0, 1'b1);
        tick();
        chk_bus("err_rsp_oor", 1'b0, 1'b1, 32'h0, 1'b1);
        tick();
        // Last in-range word is not an error
        instr_req = 1'b1; instr_addr = 32'hFFC;
        chk_bus("edge_ok", 1'b1, 1'b0, 32'h0, 1'b0);
        tick(); instr_req = 1'b0;
        tick();
        #2;
        chk32("edge_ok.err", {31'h0, instr_err}, 32'h0);
        chk32("edge_ok.rvalid", {31'h0, instr_rvalid}, 32'h1);

        // Stall: three ungranted cycles, then grant
        tick(); stall_gnt = 1'b1; instr_req = 1'b1; instr_addr = 32'h10;
        chk_bus("stall_0", 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_bus("stall_1", 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_bus("stall_2", 1'b0, 1'b0, 32'h0, 1'b0);
        tick(); stall_gnt = 1'b0;
        chk_bus("stall_gnt", 1'b1, 1'b0, 32'h0, 1'b0);
        tick(); instr_req = 1'b0;
        chk_bus("stall_T1", 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_bus("stall_rsp", 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        tick();
        chk_bus("stall_after", 1'b0, 1'b0, 32'h0, 1'b0);

        // Mid-operation reset drops pending responses
        tick(); instr_req = 1'b1; instr_addr = 32'h0;
        chk_bus("mrst_g0", 1'b1, 1'b0, 32'h0, 1'b0);
        tick(); instr_addr = 32'h4;
        chk_bus("mrst_g1", 1'b1, 1'b0, 32'h0, 1'b0);
        tick(); rst = 1'b1; instr_req = 1'b0;
        chk_bus("mrst_in", 1'b0, 1'b0, 32'h0, 1'b0);
        tick(); rst = 1'b0; instr_req = 1'b1; instr_addr = 32'h10;
        chk_bus("mrst_regnt", 1'b1, 1'b0, 32'h0, 1'b0);
        tick(); instr_req = 1'b0;
        chk_bus("mrst_quiet", 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_bus("mrst_rsp", 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // Same-cycle preload and grant returns old data
        tick(); instr_req = 1'b1; instr_addr = 32'h0;
        load_we = 1'b1; load_idx = 10'd0; load_wdata = 32'h1234_5678;
        chk_bus("raw_g", 1'b1, 1'b0, 32'h0, 1'b0);
        tick(); instr_req = 1'b0; load_we = 1'b0;
        chk_bus("raw_T1", 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_bus("raw_old", 1'b0, 1'b1, 32'h0000_00A0, 1'b0);
        tick(); instr_req = 1'b1;
        chk_bus("raw_g2", 1'b1, 1'b0, 32'h0, 1'b0);
        tick(); instr_req = 1'b0;
        tick();
        chk_bus("raw_new", 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        tick();
        chk_bus("end_idle", 1'b0, 1'b0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ibex_instr_bus_responder.md
IBEX_INSTR_BUS_RESPONDER -- requirements
Module: ibex_instr_bus_responder

Interface
REQ-001 SHALL have parameter MemWords, default 1024: depth of the backing word array (32-bit words).
REQ-002 SHALL have parameter BaseAddr, default 32'h0000_0000: byte address of word 0.
REQ-003 SHALL have parameter RspLatency, default 2, legal range 1..7: cycles from grant to rvalid.
REQ-004 SHALL have parameter MaxOutstanding, default 2, legal range 1..4: granted-but-unanswered request limit.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port instr_req_i, input, 1 bit: fetch request from the initiator.
REQ-008 SHALL have port instr_addr_i, input, 32 bits: byte address of the request.
REQ-009 SHALL have port instr_gnt_o, output, 1 bit: request accepted this cycle.
REQ-010 SHALL have port instr_rvalid_o, output, 1 bit: response valid this cycle.
REQ-011 SHALL have port instr_rdata_o, output, 32 bits: response data.
REQ-012 SHALL have port instr_err_o, output, 1 bit: bus error; asserted only together with instr_rvalid_o.
REQ-013 SHALL have port stall_gnt_i, input, 1 bit: test backpressure; forces instr_gnt_o low.
REQ-014 SHALL have port load_we_i, input, 1 bit: preload write enable.
REQ-015 SHALL have port load_idx_i, input, $clog2(MemWords) bits: preload word index.
REQ-016 SHALL have port load_wdata_i, input, 32 bits: preload data.

Function
REQ-017 SHALL drive instr_gnt_o combinationally = instr_req_i & ~stall_gnt_i & ~rst_i & (outstanding < MaxOutstanding), where outstanding is the registered count.
REQ-018 SHALL not consider a same-cycle response when evaluating REQ-017: at outstanding == MaxOutstanding, gnt is low even if rvalid is high.
REQ-019 SHALL, on a grant, compute off = instr_addr_i - BaseAddr (32-bit, wrapping) and flag an error if instr_addr_i[1:0] != 0 or off >= MemWords*4.
REQ-020 SHALL, on a grant, capture into an in-order response FIFO (depth MaxOutstanding): err flag, rdata = mem[off[..:2]] (32'h0 if err), and countdown = RspLatency-1.
REQ-021 SHALL read memory at grant time; a load_we_i write to the same word in the grant cycle is not visible (old data is returned).
REQ-022 SHALL decrement the countdown of every non-head, valid FIFO entry each cycle, saturating at 0; the head entry decrements the same way.
REQ-023 SHALL assert instr_rvalid_o in a cycle iff the FIFO is non-empty and the head countdown is 0; the head pops at the end of that cycle.
REQ-024 SHALL therefore produce rvalid exactly RspLatency cycles after the grant cycle (grant in cycle T -> rvalid in T+RspLatency), at most one response per cycle, in grant order.
REQ-025 SHALL drive instr_rdata_o and instr_err_o from the head entry when rvalid is high, and 32'h0 / 0 otherwise.
REQ-026 SHALL update outstanding: +1 on grant only, -1 on rvalid only, unchanged on both or neither; outstanding never exceeds MaxOutstanding nor underflows.
REQ-027 SHALL accept back-to-back grants on consecutive cycles while outstanding < MaxOutstanding.
REQ-028 SHALL write mem[load_idx_i] = load_wdata_i at the clock edge when load_we_i is high; preload is independent of the bus and is permitted during traffic.
REQ-029 SHALL ignore instr_addr_i when no grant is issued; an ungranted request leaves all state unchanged.

Reset
REQ-030 SHALL, while rst_i is high at a clock edge, clear outstanding, FIFO pointers and all entries' valid bits.
REQ-031 SHALL hold instr_gnt_o, instr_rvalid_o, instr_err_o at 0 and instr_rdata_o at 32'h0 during and after reset until a new grant matures.
REQ-032 SHALL drop all pending responses when reset is asserted mid-operation; no rvalid from pre-reset grants appears afterwards.
REQ-033 SHALL not reset the memory array; preloaded contents survive reset.

Verification
REQ-034 Preload mem[4]=32'hDEAD_BEEF; req addr 32'h10 granted in cycle T -> rvalid in T+2, rdata 32'hDEAD_BEEF, err 0.
REQ-035 req held high with addrs 0x0, 0x4, 0x8 on consecutive cycles -> grants on the first two, third stalled until the first rvalid retires; responses in order.
REQ-036 req addr 32'h2 (misaligned) and addr 32'h1000 (out of range, MemWords=1024) -> each granted; rvalid with err 1, rdata 32'h0.
REQ-037 stall_gnt_i high for 3 cycles with req high -> gnt 0 for those cycles, grant in the first cycle after stall_gnt_i drops, outstanding unchanged during stall.
REQ-038 Two grants pending, rst_i pulsed one cycle -> no rvalid afterwards, outstanding 0, next request granted immediately, preloaded data intact.
REQ-039 Grant on addr 0x0 and load_we_i to index 0 with 32'h1234_5678 in the same cycle -> response returns old data; a later read returns 32'h1234_5678.
